// File: rtl/uart_program_loader.sv
// uart_program_loader
// Receives 8N1 UART frames of the form SYNC, LEN, DATA[LEN], CSUM on fastClk
// and replays the payload onto the program RAM write port (prog_mode, addr,
// data_in, prog_we). done pulses on a good checksum; error is sticky until
// the next accepted SYNC byte.
//
// Handshake: there is no back-pressure anywhere. A received byte is offered
// for exactly one cycle (byte_valid_q) and is always consumed by the loader
// in that cycle; prog_we and done are likewise one-cycle strobes with no
// ready, and addr/data_in are qualified only by prog_we.
module uart_program_loader #(
  parameter int          CLKS_PER_BIT = 104,
  parameter int          MEM_DEPTH    = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       fastClk,
  input  logic       rst,
  input  logic       rx,
  output logic       prog_mode,
  output logic [3:0] addr,
  output logic [7:0] data_in,
  output logic       prog_we,
  output logic       done,
  output logic       error,
  output logic [1:0] dbg_state
);

  localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_WAIT  = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_LEN  = 2'd1,
    L_DATA = 2'd2,
    L_CSUM = 2'd3
  } ld_state_e;

  // rx synchronizer and edge history
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // receiver state
  rx_state_e        rx_st_q, rx_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // loader state
  ld_state_e  ld_q, ld_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] csum_q, csum_d;
  logic       error_q, error_d;
  logic       prog_mode_q, prog_mode_d;
  logic       prog_we_q, prog_we_d;
  logic       done_q, done_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;

  // UART receiver: start detect, mid-bit sampling, stop check
  always_comb begin
    rx_st_d      = rx_st_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        // The detection cycle itself counts toward the half-bit wait.
        if (rx_prev_q && !rx_sync_q) begin
          rx_st_d = RX_START;
          cnt_d   = CNT_W'(1);
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          if (rx_sync_q) begin
            rx_st_d = RX_IDLE;          // glitch, not a real start bit
          end else begin
            rx_st_d = RX_DATA;
            cnt_d   = '0;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          shift_d = {rx_sync_q, shift_q[7:1]};   // LSB arrives first
          cnt_d   = '0;
          if (bit_q == 3'd7) begin
            rx_st_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            rx_st_d      = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_st_d     = RX_WAIT;          // line is low; re-arm only once it idles
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_WAIT: begin
        if (rx_sync_q) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Loader: frame parsing, RAM write strobe, checksum and status flags
  always_comb begin
    ld_d        = ld_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    error_d     = error_q;
    prog_mode_d = prog_mode_q;
    addr_d      = addr_q;
    data_d      = data_q;
    prog_we_d   = 1'b0;
    done_d      = 1'b0;

    // prog_mode is held for the done cycle and released right after it.
    if (done_q) prog_mode_d = 1'b0;

    if (frame_err_q) begin
      error_d     = 1'b1;
      prog_mode_d = 1'b0;
      ld_d        = L_IDLE;
    end else if (byte_valid_q) begin
      case (ld_q)
        L_IDLE: begin
          if (shift_q == SYNC_BYTE) begin
            error_d = 1'b0;
            csum_d  = 8'd0;
            ld_d    = L_LEN;
          end
        end
        L_LEN: begin
          if (shift_q == 8'd0 || {24'd0, shift_q} > 32'(MEM_DEPTH)) begin
            error_d = 1'b1;
            ld_d    = L_IDLE;
          end else begin
            len_d       = shift_q;
            idx_d       = 8'd0;
            prog_mode_d = 1'b1;
            ld_d        = L_DATA;
          end
        end
        L_DATA: begin
          prog_we_d = 1'b1;
          addr_d    = idx_q[3:0];
          data_d    = shift_q;
          csum_d    = csum_q + shift_q;
          idx_d     = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) ld_d = L_CSUM;
        end
        L_CSUM: begin
          if (shift_q == csum_q) begin
            done_d = 1'b1;
          end else begin
            error_d     = 1'b1;
            prog_mode_d = 1'b0;
          end
          ld_d = L_IDLE;
        end
        default: ld_d = L_IDLE;
      endcase
    end
  end

  // State registers for synchronizer, receiver and loader
  always_ff @(posedge fastClk or negedge rst) begin
    if (!rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_st_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ld_q         <= L_IDLE;
      len_q        <= 8'd0;
      idx_q        <= 8'd0;
      csum_q       <= 8'd0;
      error_q      <= 1'b0;
      prog_mode_q  <= 1'b0;
      prog_we_q    <= 1'b0;
      done_q       <= 1'b0;
      addr_q       <= 4'd0;
      data_q       <= 8'd0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_st_q      <= rx_st_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ld_q         <= ld_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      error_q      <= error_d;
      prog_mode_q  <= prog_mode_d;
      prog_we_q    <= prog_we_d;
      done_q       <= done_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign prog_mode = prog_mode_q;
  assign addr      = addr_q;
  assign data_in   = data_q;
  assign prog_we   = prog_we_q;
  assign done      = done_q;
  assign error     = error_q;
  assign dbg_state = ld_q;

endmodule
